// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine sequencer and its scoring logic.
package slot_pkg;

    localparam int SYM_W = 3;
    localparam logic [SYM_W-1:0] SYM_SEVEN = 3'd7;
    localparam int PAY_W = 8;

    localparam int DEF_PAY_JACKPOT = 50;
    localparam int DEF_PAY_TRIPLE  = 10;
    localparam int DEF_PAY_PAIR    = 2;

    typedef enum logic [2:0] {
        IDLE,
        SPIN,
        STOP,
        EVAL,
        PAYOUT
    } state_t;

endpackage

// File: rtl/slot_spin_controller_if.sv
// Player-side inputs and display-side outputs of the spin controller.
interface slot_spin_controller_if #(
    parameter int CREDIT_W = 8
);
    import slot_pkg::*;

    logic                 coin;
    logic                 spin_req;
    logic [SYM_W-1:0]     sym_in;
    logic                 reel_run;
    logic [SYM_W-1:0]     reel1;
    logic [SYM_W-1:0]     reel2;
    logic [SYM_W-1:0]     reel3;
    logic [CREDIT_W-1:0]  credits;
    logic                 win;
    logic [PAY_W-1:0]     last_payout;
    logic                 busy;

    modport master (
        output coin, spin_req, sym_in,
        input  reel_run, reel1, reel2, reel3, credits, win, last_payout, busy
    );

    modport slave (
        input  coin, spin_req, sym_in,
        output reel_run, reel1, reel2, reel3, credits, win, last_payout, busy
    );

endinterface

// File: rtl/slot_payout_eval.sv
// Scores three stopped reels; purely combinational so display logic can reuse it.
module slot_payout_eval
    import slot_pkg::*;
#(
    parameter int PAY_JACKPOT = DEF_PAY_JACKPOT,
    parameter int PAY_TRIPLE  = DEF_PAY_TRIPLE,
    parameter int PAY_PAIR    = DEF_PAY_PAIR
) (
    input  logic [SYM_W-1:0] reel1,
    input  logic [SYM_W-1:0] reel2,
    input  logic [SYM_W-1:0] reel3,
    output logic [PAY_W-1:0] payout
);

    logic pair;
    logic triple;

    assign pair   = (reel1 == reel2);
    assign triple = pair && (reel2 == reel3);

    always_comb begin
        payout = '0;
        if (triple) begin
            payout = (reel1 == SYM_SEVEN) ? PAY_W'(PAY_JACKPOT) : PAY_W'(PAY_TRIPLE);
        end else if (pair) begin
            payout = PAY_W'(PAY_PAIR);
        end
    end

endmodule

// File: rtl/slot_spin_controller.sv
// Slot game sequencer: credit balance, timed reel stops, scoring and one-per-cycle payout.
module slot_spin_controller
    import slot_pkg::*;
#(
    parameter int CREDIT_W    = 8,
    parameter int SPIN_CYCLES = 16,
    parameter int STOP_GAP    = 8,
    parameter int PAY_JACKPOT = DEF_PAY_JACKPOT,
    parameter int PAY_TRIPLE  = DEF_PAY_TRIPLE,
    parameter int PAY_PAIR    = DEF_PAY_PAIR
) (
    input  logic                   clock,
    input  logic                   reset,
    slot_spin_controller_if.slave  bus
);

    localparam int TIMER_MAX = (SPIN_CYCLES > STOP_GAP) ? SPIN_CYCLES : STOP_GAP;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] SPIN_RELOAD = TIMER_W'(SPIN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_RELOAD  = TIMER_W'(STOP_GAP - 1);
    localparam logic [CREDIT_W+1:0] CREDIT_MAX = {2'b00, {CREDIT_W{1'b1}}};

    state_t              state;
    logic [TIMER_W-1:0]  timer;
    logic [1:0]          idx;
    logic [PAY_W-1:0]    remaining;
    logic [CREDIT_W-1:0] credits;
    logic [SYM_W-1:0]    reel1;
    logic [SYM_W-1:0]    reel2;
    logic [SYM_W-1:0]    reel3;
    logic                win;
    logic [PAY_W-1:0]    last_payout;
    logic [PAY_W-1:0]    payout;

    logic                spin_accept;
    logic                payout_inc;
    logic [CREDIT_W+1:0] credit_sum;
    logic [CREDIT_W-1:0] credit_next;

    slot_payout_eval #(
        .PAY_JACKPOT (PAY_JACKPOT),
        .PAY_TRIPLE  (PAY_TRIPLE),
        .PAY_PAIR    (PAY_PAIR)
    ) u_eval (
        .reel1  (reel1),
        .reel2  (reel2),
        .reel3  (reel3),
        .payout (payout)
    );

    // A coin in the same cycle pays for the spin, so an empty balance never underflows.
    assign spin_accept = (state == IDLE) && bus.spin_req && ((credits != '0) || bus.coin);
    assign payout_inc  = (state == PAYOUT);

    assign credit_sum  = {2'b00, credits}
                       + (CREDIT_W+2)'(bus.coin)
                       + (CREDIT_W+2)'(payout_inc)
                       - (CREDIT_W+2)'(spin_accept);
    assign credit_next = (credit_sum > CREDIT_MAX) ? CREDIT_MAX[CREDIT_W-1:0]
                                                   : credit_sum[CREDIT_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            idx         <= '0;
            remaining   <= '0;
            credits     <= '0;
            reel1       <= '0;
            reel2       <= '0;
            reel3       <= '0;
            win         <= 1'b0;
            last_payout <= '0;
        end else begin
            credits <= credit_next;
            case (state)
                IDLE: begin
                    if (spin_accept) begin
                        win         <= 1'b0;
                        last_payout <= '0;
                        reel1       <= '0;
                        reel2       <= '0;
                        reel3       <= '0;
                        timer       <= SPIN_RELOAD;
                        state       <= SPIN;
                    end
                end
                SPIN: begin
                    if (timer == '0) begin
                        timer <= GAP_RELOAD;
                        idx   <= '0;
                        state <= STOP;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                STOP: begin
                    if (timer == '0) begin
                        timer <= GAP_RELOAD;
                        idx   <= idx + 2'd1;
                        case (idx)
                            2'd0:    reel1 <= bus.sym_in;
                            2'd1:    reel2 <= bus.sym_in;
                            default: begin
                                reel3 <= bus.sym_in;
                                idx   <= '0;
                                state <= EVAL;
                            end
                        endcase
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                EVAL: begin
                    last_payout <= payout;
                    win         <= (payout != '0);
                    remaining   <= payout;
                    state       <= (payout == '0) ? IDLE : PAYOUT;
                end
                PAYOUT: begin
                    // Saturated increments are dropped, but the countdown still runs its full length.
                    remaining <= remaining - PAY_W'(1);
                    if (remaining == PAY_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.reel_run    = (state == SPIN) || (state == STOP);
    assign bus.busy        = (state != IDLE);
    assign bus.credits     = credits;
    assign bus.reel1       = reel1;
    assign bus.reel2       = reel2;
    assign bus.reel3       = reel3;
    assign bus.win         = win;
    assign bus.last_payout = last_payout;

endmodule

// File: doc/slot_spin_controller.md
Name: slot_spin_controller

Overview:
- Game sequencer for the slot machine datapath: holds the credit balance and accepts coins and spin requests.
- On each spin, runs the reels for a fixed time and stops them one at a time by latching a free-running symbol source.
- Evaluates the three stopped symbols and pays winnings back into credits one per cycle.
- Sits between the player inputs and the symbol generator/display.

Parameters:
- CREDIT_W, 8, credit counter width; balance saturates at 2^CREDIT_W-1.
- SPIN_CYCLES, 16, cycles all reels run before the first stop (>=1).
- STOP_GAP, 8, cycles between successive reel stops (>=1).
- PAY_JACKPOT, 50, payout for three 7s.
- PAY_TRIPLE, 10, payout for any other three-of-a-kind.
- PAY_PAIR, 2, payout when reel1==reel2 and not a triple.

Ports:
- clock, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-high reset.
- coin, input, 1, one-cycle pulse that adds one credit.
- spin_req, input, 1, one-cycle spin request pulse.
- sym_in, input, 3, free-running symbol from the generator, sampled at stops.
- reel_run, output, 1, reels animating (SPIN and STOP states).
- reel1, output, 3, stopped symbol, reel 1.
- reel2, output, 3, stopped symbol, reel 2.
- reel3, output, 3, stopped symbol, reel 3.
- credits, output, CREDIT_W, current balance.
- win, output, 1, last completed spin paid more than 0.
- last_payout, output, 8, payout of last completed spin.
- busy, output, 1, state is not IDLE.

Behaviour:
- Reset (async): state IDLE, credits=0, reel1..3=0, win=0, last_payout=0, reel_run=0, busy=0, timers and index = 0.
- States: IDLE, SPIN, STOP, EVAL, PAYOUT. All outputs are registered or decoded from the state register; no input-to-output combinational path.
- IDLE, spin acceptance: at edge E0, accept if spin_req=1 and (credits>0 or coin=1).
- On acceptance: cost 1 credit, so net credits change = coin - 1. Clear win, last_payout and reel1..3 to 0. Enter SPIN with timer=SPIN_CYCLES-1.
- A spin_req that is not accepted is dropped, with no side effects.
- SPIN: reel_run=1. When timer==0, enter STOP with timer=STOP_GAP-1 and idx=0; otherwise decrement the timer.
- STOP: reel_run=1. When timer==0, latch sym_in into reel[idx+1], increment idx and reload the timer. After the third latch, enter EVAL.
- Stop timing: reel1 latches at edge E0+SPIN_CYCLES+STOP_GAP, reel2 at +2*STOP_GAP, reel3 at +3*STOP_GAP.
- EVAL (one cycle, reel_run=0): compute payout p.
  - All three reels equal and value 7: p=PAY_JACKPOT.
  - All three equal otherwise: p=PAY_TRIPLE.
  - Else reel1==reel2: p=PAY_PAIR.
  - Else p=0.
- Leaving EVAL: register last_payout=p and win=(p!=0). If p=0 go to IDLE; else go to PAYOUT with remaining=p.
- PAYOUT: each cycle adds 1 to credits and decrements remaining. When remaining reaches 0, go to IDLE, so PAYOUT lasts exactly p cycles.
- Credit arithmetic: credits += coin + payout_inc - spin_cost each cycle. The sum saturates at max and never goes below 0. Excess at saturation is discarded while remaining still counts down.
- coin is accepted in every state. coin and a payout increment in the same cycle give +2, saturating.
- spin_req outside IDLE is ignored.
- win and last_payout hold until the next accepted spin.
- Reset asserted mid-operation returns immediately to the reset state. Credits are lost and any pending payout is abandoned.

Decomposition:
- Shared package slot_pkg:
  - SYM_W=3 and SYM_SEVEN=3'd7.
  - State enum (IDLE, SPIN, STOP, EVAL, PAYOUT).
  - Default payout constants.
- One sub-module, slot_payout_eval: combinational mapping of reel1..3 to the 8-bit payout, reused by the display scoring logic.
- Credit saturation adder stays inline.

Test Plan:
All scenarios run with SPIN_CYCLES=4 and STOP_GAP=2.
1. Credits=0, pulse spin_req -> stays IDLE, busy=0, credits=0. Then coin and spin_req together -> accepted, credits stays 0, busy=1 next cycle.
2. Credits=1, spin with sym_in held at 7 -> reel1..3 = 7 at edges E0+6, E0+8 and E0+10; EVAL; then win=1, last_payout=50; credits rises 0 to 50 over 50 cycles; then IDLE.
3. Credits=3, sym_in sequence 2,2,5 at the stops -> win=1, last_payout=2, credits 2 to 4, PAYOUT lasts 2 cycles. Next spin with 1,4,6 -> win=0, last_payout=0, credits=3, no PAYOUT state.
4. Credits=250, triple 3 (p=10), coin pulsed during PAYOUT -> that cycle adds 2; credits saturate at 255; FSM still returns to IDLE after 10 PAYOUT cycles.
5. spin_req pulsed during SPIN, STOP and PAYOUT -> no restart, no extra debit, stop timing unchanged.
6. reset asserted asynchronously mid-PAYOUT (credits=20, remaining 30) -> outputs return to reset values without waiting for a clock edge; the next coin gives credits=1.
